// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int REG_W             = 5;
  localparam int DRAIN_CYC_DEFAULT = 2;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_HALTED   = 2'd2,
    ST_WAIT_REL = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/fwd_sel.sv
// One EX-operand forwarding select; the youngest producer (EX/MEM) beats MEM/WB.
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       sel
);

  always_comb begin
    // NOTE: default assigned first so every path drives sel and no latch is inferred.
    sel = FWD_RF;
    if (src != '0) begin
      if (mem_reg_write && (mem_rd == src))     sel = FWD_MEM;
      else if (wb_reg_write && (wb_rd == src))  sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and syscall-halt controller for the 5-stage MIPS pipeline.
// Define PIPE_PERF_CNT_EN to build the cycle/stall/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_redirect,
  input  logic             ex_halt,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             resume,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                DCNT_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYC - 1);

  ctrl_state_e       state;
  logic [DCNT_W-1:0] drain_cnt;
  logic              resume_d;

  fwd_sel u_fwd_a (
    .src(ex_rs), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(fwd_a)
  );

  fwd_sel u_fwd_b (
    .src(ex_rt), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(fwd_b)
  );

  // Hazard resolution in priority order: halt FSM, redirect, load-use, jump.
  logic resume_rise, active, halt_req, load_use;
  logic do_redirect, do_stall, do_jump;

  assign resume_rise = resume & ~resume_d;
  assign active      = (state == ST_RUN) || (state == ST_WAIT_REL);
  assign halt_req    = (state == ST_RUN) && ex_halt;
  assign load_use    = ex_mem_to_reg && (ex_rd != '0) &&
                       ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
  assign do_redirect = active && !halt_req && ex_redirect;
  assign do_stall    = active && !halt_req && !ex_redirect && load_use;
  assign do_jump     = active && !halt_req && !ex_redirect && !load_use && id_jump;

  assign pc_stall    = !active || halt_req || do_stall;
  assign if_id_stall = !active || do_stall;
  assign if_id_flush = halt_req || do_redirect || do_jump;
  assign id_ex_flush = !active || halt_req || do_redirect || do_stall;

  // ex_reg_write only matters for the forwarding of the following cycle (seen as mem_reg_write).
  logic unused_ok;
  assign unused_ok = ex_reg_write;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update on the same edge, order-independent.
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      resume_d  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      resume_d <= resume;
      unique case (state)
        ST_RUN: begin
          if (ex_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_HALTED: begin
          if (resume_rise) begin
            state  <= ST_WAIT_REL;
            halted <= 1'b0;
          end
        end
        ST_WAIT_REL: state <= ST_RUN;
        default:     state <= ST_RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != ST_HALTED)        cycle_cnt <= cycle_cnt + 1'b1;
      if (do_stall)                  stall_cnt <= stall_cnt + 1'b1;
      if (do_redirect || do_jump)    flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline; sits beside the instruction decoder and drives the stall, flush and forwarding selects for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also owns the syscall halt state machine: it freezes and drains the pipe on a halting syscall and restarts it on a resume pulse. Optional performance counters report cycles, stalls and flushes to the board display.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter
- DRAIN_CYC, 2, cycles allowed for MEM/WB to retire before HALTED

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_rs, id_rt  in  5  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs/rt
- id_jump  in  1  j/jal resolved in ID
- ex_rs, ex_rt  in  5  source registers of the instruction in EX
- ex_rd  in  5  destination of EX instruction; ex_reg_write, ex_mem_to_reg  in  1
- ex_redirect  in  1  taken beq/bne or jr resolved in EX
- ex_halt  in  1  syscall in EX with halt condition ($v0 == 10)
- mem_rd  in  5; mem_reg_write  in  1
- wb_rd  in  5; wb_reg_write  in  1
- resume  in  1  level from board button, already debounced
- pc_stall, if_id_stall  out  1  hold PC / IF/ID
- if_id_flush, id_ex_flush  out  1  load bubble into IF/ID / ID/EX
- fwd_a, fwd_b  out  2  EX operand select: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
- halted  out  1  FSM in HALTED
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Register $0 never produces a hazard or forward.
- Forwarding (combinational): fwd_a = 1 if mem_reg_write & mem_rd == ex_rs; else 2 if wb_reg_write & wb_rd == ex_rs; else 0. fwd_b identical on ex_rt. MEM match wins over WB.
- Load-use: ex_mem_to_reg & ex_rd != 0 & ((id_uses_rs & ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)) -> pc_stall, if_id_stall, id_ex_flush.
- ex_redirect -> if_id_flush, id_ex_flush; overrides load-use (no stall asserted).
- id_jump -> if_id_flush only; load-use stall wins over id_jump (jump re-resolves next cycle).
- Priority: halt FSM > ex_redirect > load-use > id_jump.
- FSM states RUN, DRAIN, HALTED, WAIT_REL:
  - RUN: ex_halt -> DRAIN; id_ex_flush and if_id_flush asserted that cycle, pc_stall held from then on.
  - DRAIN: pc_stall, if_id_stall, id_ex_flush held; down-counter from DRAIN_CYC-1; at 0 -> HALTED.
  - HALTED: halted = 1, same holds; rising edge of resume (internal 1-cycle-delayed copy) -> WAIT_REL.
  - WAIT_REL: holds released, -> RUN next cycle. ex_halt ignored in this state (bubble in EX).
- resume seen outside HALTED is ignored; resume high at entry to HALTED does not count as an edge.

## Timing
- Forward/stall/flush outputs combinational from inputs and FSM state; no added latency.
- ex_halt in cycle N: DRAIN in N+1, HALTED in N+1+DRAIN_CYC.
- Resume edge sampled in cycle M: WAIT_REL M+1, RUN M+2, PC advances at M+2 edge.
- Reset: FSM = RUN, drain counter 0, resume history 0, all counters 0, halted 0. Reset mid-DRAIN/HALTED returns to RUN on the next edge.
- Counters: cycle_cnt increments every non-reset cycle while not HALTED; stall_cnt on load-use stall cycles; flush_cnt on ex_redirect or id_jump cycles actually flushing. All wrap modulo 2^CNT_W.

## Configuration
- PIPE_PERF_CNT_EN defined: three counters implemented as above.
- Undefined: counter registers removed, cycle_cnt/stall_cnt/flush_cnt tied to 0; all other behaviour unchanged.

## Structure
- Package pipe_ctrl_pkg: fwd select constants (FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2), FSM state encoding, default DRAIN_CYC.
- Sub-module fwd_sel, instantiated twice (rs and rt), computes one 2-bit select from src, mem/wb rd and write enables.

## Test plan
- ex: mem_rd = 8, mem_reg_write = 1, wb_rd = 8, wb_reg_write = 1, ex_rs = 8 -> fwd_a = 1; clear mem_reg_write -> fwd_a = 2; ex_rs = 0 -> fwd_a = 0.
- lw $9 in EX (ex_mem_to_reg = 1, ex_rd = 9), id_rs = 9, id_uses_rs = 1 -> pc_stall = if_id_stall = id_ex_flush = 1 one cycle; stall_cnt += 1.
- Same load-use with ex_redirect = 1 -> if_id_flush = id_ex_flush = 1, pc_stall = 0, flush_cnt += 1.
- ex_halt pulse at cycle 10, DRAIN_CYC = 2 -> halted = 1 from cycle 13; cycle_cnt frozen; resume rise at 20 -> halted = 0 at 21, pc_stall = 0 at 22.
- rst asserted during DRAIN -> next cycle all outputs at reset values, FSM RUN.
- Build without PIPE_PERF_CNT_EN, 100 cycles with stalls -> all counters read 0.
